// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the pipelined ALU.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_SHLA = 4'd6;
  localparam logic [3:0] OP_SHLB = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift-count width: must hold the value N itself, hence the extra bit.
  function automatic int cw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_pipe_iter.sv
// Iterative datapath: one-bit-per-cycle shifts and shift-add unsigned multiply.
module alu_pipe_iter
  import alu_pipe_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cw_of(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  input  logic [3:0]   ld_op,
  input  logic [3:0]   run_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] res_nxt,
  output logic         cout_nxt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N:0]    psum;

  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cout_nxt = 1'b0;
    psum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    if (start) begin
      mcand_d = a;
      acc_d   = '0;
      if (ld_op == OP_MUL) begin
        sh_d  = b;
        cnt_d = CW'(N);
      end else begin
        sh_d  = a;
        cnt_d = (32'(b) >= N) ? CW'(N) : b[CW-1:0];
      end
    end else if (step) begin
      cnt_d = cnt_q - 1'b1;
      case (run_op)
        OP_SLL: begin
          sh_d     = {sh_q[N-2:0], 1'b0};
          cout_nxt = sh_q[N-1];
        end
        OP_SRL: begin
          sh_d     = {1'b0, sh_q[N-1:1]};
          cout_nxt = sh_q[0];
        end
        OP_SRA: begin
          sh_d     = {sh_q[N-1], sh_q[N-1:1]};
          cout_nxt = sh_q[0];
        end
        default: begin
          // {acc, sh} shifts right as one 2N-bit product register
          acc_d    = psum[N:1];
          sh_d     = {psum[0], sh_q[N-1:1]};
          cout_nxt = |psum[N:1];
        end
      endcase
    end
  end

  assign last    = (cnt_q == CW'(1));
  assign res_nxt = sh_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ALU with valid/ready handshake: single-cycle ops, iterative shifts/multiply, flags.
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | iterative shift or multiply stepping one bit per cycle
// DONE  | result and flags held until the consumer takes them
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cw_of(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   OpCode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic         Z_flag,
  output logic         C_flag,
  output logic         C_out,
  output logic         V_flag,
  output logic         Err
);

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic         gt_q, gt_d;
  logic [N-1:0] result_q, result_d;
  logic         z_q, z_d, cf_q, cf_d, co_q, co_d, v_q, v_d, err_q, err_d;
  logic         carry_q, carry_d, ovalid_q, ovalid_d;

  logic [N:0]   add_w, sub_w;
  logic [N-1:0] sc_res, iter_res;
  logic         sc_co, sc_v, accept, illegal, shift_zero;
  logic         iter_start, iter_last, iter_co;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign illegal    = OpCode > OP_MUL;
  assign shift_zero = is_shift(OpCode) && (B == '0);

  always_comb begin
    add_w  = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, (OpCode == OP_ADC) && carry_q};
    sub_w  = {1'b0, A} - {1'b0, B};
    sc_res = A;
    sc_co  = 1'b0;
    sc_v   = 1'b0;
    case (OpCode)
      OP_ADD, OP_ADC: begin
        sc_res = add_w[N-1:0];
        sc_co  = add_w[N];
        sc_v   = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[N-1:0];
        sc_co  = sub_w[N];
        sc_v   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_CMP:  sc_res = {{(N-1){1'b0}}, A > B};
      OP_SHLA: begin
        sc_res = {A[N-2:0], 1'b0};
        sc_co  = A[N-1];
      end
      OP_SHLB: begin
        sc_res = {B[N-2:0], 1'b0};
        sc_co  = B[N-1];
      end
      default: sc_res = A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    gt_d       = gt_q;
    result_d   = result_q;
    z_d        = z_q;
    cf_d       = cf_q;
    co_d       = co_q;
    v_d        = v_q;
    err_d      = err_q;
    carry_d    = carry_q;
    ovalid_d   = ovalid_q;
    iter_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = OpCode;
          gt_d = A > B;
          if ((OpCode == OP_MUL) || (is_shift(OpCode) && !shift_zero)) begin
            iter_start = 1'b1;
            state_d    = BUSY;
          end else begin
            state_d  = DONE;
            ovalid_d = 1'b1;
            result_d = sc_res;
            if (illegal) begin
              z_d   = 1'b0;
              cf_d  = 1'b0;
              co_d  = 1'b0;
              v_d   = 1'b0;
              err_d = 1'b1;
            end else begin
              z_d     = (sc_res == '0);
              cf_d    = A > B;
              co_d    = sc_co;
              v_d     = sc_v;
              err_d   = 1'b0;
              carry_d = sc_co;
            end
          end
        end
      end
      BUSY: begin
        if (iter_last) begin
          state_d  = DONE;
          ovalid_d = 1'b1;
          result_d = iter_res;
          z_d      = (iter_res == '0);
          cf_d     = gt_q;
          co_d     = iter_co;
          v_d      = 1'b0;
          err_d    = 1'b0;
          carry_d  = iter_co;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  alu_pipe_iter #(.N(N), .CW(CW)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (iter_start),
    .step     (state_q == BUSY),
    .ld_op    (OpCode),
    .run_op   (op_q),
    .a        (A),
    .b        (B),
    .last     (iter_last),
    .res_nxt  (iter_res),
    .cout_nxt (iter_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      gt_q     <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      cf_q     <= 1'b0;
      co_q     <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      gt_q     <= gt_d;
      result_q <= result_d;
      z_q      <= z_d;
      cf_q     <= cf_d;
      co_q     <= co_d;
      v_q      <= v_d;
      err_q    <= err_d;
      carry_q  <= carry_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign out_valid = ovalid_q;
  assign Result    = result_q;
  assign Z_flag    = z_q;
  assign C_flag    = cf_q;
  assign C_out     = co_q;
  assign V_flag    = v_q;
  assign Err       = err_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand/result width in bits (N >= 4).
REQ-002 SHALL have parameter CW, default $clog2(N)+1, giving the shift-count width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a request.
REQ-007 SHALL have ports A and B, input, N bits each: operands.
REQ-008 SHALL have port OpCode, input, 4 bits: operation select.
REQ-009 SHALL have port out_valid, output, 1 bit: Result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port Result, output, N bits: registered result.
REQ-012 SHALL have ports Z_flag, C_flag, C_out, V_flag and Err, output, 1 bit each: zero, unsigned A>B, carry/borrow, signed overflow, illegal opcode.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE, with in_ready = (state==IDLE) && !rst.
REQ-014 SHALL accept a request on in_valid && in_ready, latching A, B and OpCode.
REQ-015 SHALL execute single-cycle ops 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP (Result = A>B unsigned), 6 A<<1, 7 B<<1 and 8 ADC (A+B+stored carry); for these, IDLE goes to DONE and out_valid is high on the next cycle.
REQ-016 SHALL execute iterative ops 9 SLL, 10 SRL and 11 SRA of A by k = min(B, N), one bit per cycle: BUSY for k cycles, then DONE; k=0 goes directly to DONE with Result=A.
REQ-017 SHALL execute iterative op 12 MUL as unsigned shift-add over exactly N BUSY cycles, so out_valid is high N+1 cycles after accept.
REQ-018 SHALL treat opcodes 13-15 as illegal: Result=A, Err=1, all other flags 0, latency 1; Err SHALL be 0 for all legal ops.
REQ-019 SHALL compute ADD/ADC/SUB at N+1 bits, where C_out = bit N (carry for ADD/ADC, borrow A<B for SUB) and V_flag = two's-complement overflow.
REQ-020 SHALL set C_out = A[N-1] for op 6 and B[N-1] for op 7.
REQ-021 SHALL set C_out = last bit shifted out for SLL/SRL/SRA (0 when k=0).
REQ-022 SHALL set C_out = OR of product bits [2N-1:N] for MUL, with Result = product[N-1:0].
REQ-023 SHALL set C_out = 0 and V_flag = 0 for logic ops and CMP, and V_flag = 0 for shifts and MUL.
REQ-024 SHALL set Z_flag = (Result==0) and C_flag = (A>B) unsigned on the latched operands for every op.
REQ-025 SHALL hold Result and all flags stable in DONE while out_valid && !out_ready.
REQ-026 SHALL return from DONE to IDLE on out_valid && out_ready, with no overlap, so in_ready is 0 in BUSY and DONE.
REQ-027 SHALL ignore in_valid outside IDLE and SHALL ignore changes to A, B and OpCode after accept.
REQ-028 SHALL update the stored carry used by ADC only when an op 0-12 completes (DONE entry), loading that op's C_out.
REQ-029 SHALL cause SRA to fill from A[N-1]; with B >= N, SRA yields all sign bits and SLL/SRL yield 0.

Reset
REQ-030 SHALL, while rst is high, force state to IDLE; out_valid, Result, Z_flag, C_flag, C_out, V_flag, Err and the stored carry to 0; and in_ready to 0.
REQ-031 SHALL let rst abort any BUSY or DONE operation without producing out_valid; the first request is accepted in the cycle after rst falls.

Structure
REQ-032 SHALL place opcode localparams (OP_ADD..OP_MUL), the state encoding and the CW derivation in shared package alu_pipe_pkg.
REQ-033 SHALL place the iterative shift/multiply datapath (counter, shift register, accumulator) in sub-module alu_pipe_iter; the top holds the FSM, single-cycle ops, flags and handshake.

Verification
REQ-034 SHALL verify: N=8, ADD A=0xFF B=0x01 -> Result 0x00, C_out 1, Z_flag 1, V_flag 0, out_valid 1 cycle after accept; then ADC A=0x00 B=0x00 -> Result 0x01.
REQ-035 SHALL verify: SUB A=0x80 B=0x01 -> Result 0x7F, V_flag 1, C_out 0, C_flag 1.
REQ-036 SHALL verify: MUL A=0x10 B=0x10 -> Result 0x00, C_out 1, Z_flag 1, out_valid exactly 9 cycles after accept.
REQ-037 SHALL verify: SRA A=0x80 B=3 -> Result 0xF0 after 3 BUSY cycles; SRA B=9 -> 0xFF; SLL B=0 -> Result=A, latency 1.
REQ-038 SHALL verify: out_ready held low 5 cycles in DONE -> Result and flags stable, in_ready 0, in_valid pulses ignored.
REQ-039 SHALL verify: rst pulsed in cycle 4 of MUL -> out_valid never rises, in_ready 1 the cycle after rst falls, following ADC 0+0 -> Result 0x00.
